dvp_capture: RTL and testbench

- Camera-side front end for the DVP video path. Samples an 8-bit DVP camera bus and pairs bytes into 16-bit RGB565 pixels.
- Produces the active-high vin_vs / vin_de / vin_data[15:0] stream that the frame-buffer DMA write port consumes on vin_clk.
- Adds frame-aligned start/stop, a settle-frame skip after enable, and line/frame geometry measurement for software status.

---
 rtl/dvp_capture.sv | 189 ++++++++++++++++++
 tb/tb_dvp_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture.sv
// rtl/dvp_capture.sv - DVP camera byte bus to RGB565 pixel stream with frame-aligned capture control
//
// Ports:
//   clk, rst_n           camera PCLK (also vin_clk downstream), async active-low reset
//   cap_en               capture enable level; start/stop take effect on frame boundaries
//   dvp_vsync            camera vertical sync, active level set by VS_POL
//   dvp_href, dvp_data   camera line-valid and byte bus
//   vin_vs/de/data       active-high frame sync, pixel valid, RGB565 pixel (first byte in [15:8])
//   frame_cnt            captured-frame count (wraps)
//   h_pixels, v_lines    geometry of the last completed line / frame
//   frame_done           one-cycle pulse per closed captured frame
//   odd_err              sticky: a line ended with an unpaired byte
module dvp_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1,
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_en,
  input  logic               dvp_vsync,
  input  logic               dvp_href,
  input  logic [7:0]         dvp_data,
  output logic               vin_vs,
  output logic               vin_de,
  output logic [15:0]        vin_data,
  output logic [15:0]        frame_cnt,
  output logic [H_WIDTH-1:0] h_pixels,
  output logic [V_WIDTH-1:0] v_lines,
  output logic               frame_done,
  output logic               odd_err
);

  localparam logic VS_LVL = (VS_POL != 0);
  localparam int   SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [SKIP_W-1:0]  SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam logic [H_WIDTH-1:0] H_MAX     = {H_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, CAPTURE} state_t;

  state_t              state, state_nxt;
  logic                vs_r, href_r, vs_act_d, href_d;
  logic [7:0]          data_r, hi_byte;
  logic                vs_act, vs_rise, href_fall;
  logic                byte_valid, line_end;
  logic                byte_phase;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [H_WIDTH-1:0]  h_cnt;
  logic [V_WIDTH-1:0]  v_cnt;
  logic                enter_cap, close_frame, skip_clr, skip_inc, clr_odd;

  // Input stage. vs_r resets to the inactive level so that leaving reset
  // with vsync idle never fabricates a leading edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r     <= ~VS_LVL;
      href_r   <= 1'b0;
      data_r   <= 8'h00;
      vs_act_d <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      vs_r     <= dvp_vsync;
      href_r   <= dvp_href;
      data_r   <= dvp_data;
      vs_act_d <= vs_act;
      href_d   <= href_r;
    end
  end

  assign vs_act     = ~(vs_r ^ VS_LVL);
  assign vs_rise    = vs_act & ~vs_act_d;
  assign href_fall  = href_d & ~href_r;
  // Lines during vsync are ignored entirely, including their line end.
  assign byte_valid = (state == CAPTURE) & href_r & ~vs_act;
  assign line_end   = (state == CAPTURE) & href_fall & ~vs_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    enter_cap   = 1'b0;
    close_frame = 1'b0;
    skip_clr    = 1'b0;
    skip_inc    = 1'b0;
    clr_odd     = 1'b0;
    case (state)
      IDLE: begin
        if (cap_en) begin
          clr_odd   = 1'b1;
          state_nxt = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (!cap_en) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          if (SKIP_FRAMES == 0) begin
            state_nxt = CAPTURE;
            enter_cap = 1'b1;
          end else begin
            state_nxt = SKIP;
            skip_clr  = 1'b1;
          end
        end
      end
      SKIP: begin
        if (!cap_en) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          if (skip_cnt == SKIP_LAST) begin
            state_nxt = CAPTURE;
            enter_cap = 1'b1;
          end else begin
            skip_inc = 1'b1;
          end
        end
      end
      CAPTURE: begin
        // Stop only at a frame boundary so a frame is never cut short.
        if (vs_rise) begin
          close_frame = 1'b1;
          if (!cap_en) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_vs     <= 1'b0;
      vin_de     <= 1'b0;
      vin_data   <= 16'h0000;
      frame_cnt  <= 16'h0000;
      h_pixels   <= '0;
      v_lines    <= '0;
      frame_done <= 1'b0;
      odd_err    <= 1'b0;
      byte_phase <= 1'b0;
      hi_byte    <= 8'h00;
      skip_cnt   <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
    end else begin
      frame_done <= close_frame;
      vin_de     <= 1'b0;
      // vs_act is one stage behind the pins; registering it here lines
      // vin_vs up with the pixel path.
      vin_vs     <= vs_act & ((state == CAPTURE) | enter_cap);

      if (skip_clr)      skip_cnt <= '0;
      else if (skip_inc) skip_cnt <= skip_cnt + SKIP_W'(1);

      if (clr_odd) odd_err <= 1'b0;

      if (state != CAPTURE) begin
        byte_phase <= 1'b0;
        h_cnt      <= '0;
        v_cnt      <= '0;
      end else if (close_frame) begin
        v_lines    <= v_cnt;
        v_cnt      <= '0;
        h_cnt      <= '0;
        byte_phase <= 1'b0;
        frame_cnt  <= frame_cnt + 16'd1;
      end else if (line_end) begin
        byte_phase <= 1'b0;
        if (byte_phase) odd_err <= 1'b1;
        h_pixels   <= h_cnt;
        h_cnt      <= '0;
        if (h_cnt != '0) v_cnt <= v_cnt + V_WIDTH'(1);
      end else if (byte_valid) begin
        byte_phase <= ~byte_phase;
        if (!byte_phase) begin
          hi_byte <= data_r;
        end else begin
          vin_data <= {hi_byte, data_r};
          vin_de   <= 1'b1;
          if (h_cnt != H_MAX) h_cnt <= h_cnt + H_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_capture.sv
// tb/tb_dvp_capture.sv - scoreboard bench for dvp_capture with a frame-level reference model
module tb_dvp_capture;

  localparam int SKIP = 2;
  localparam int VSP  = 0;

  logic        clk = 1'b0;
  logic        rst_n, cap_en, dvp_vsync, dvp_href;
  logic [7:0]  dvp_data;
  logic        vin_vs, vin_de, frame_done, odd_err;
  logic [15:0] vin_data, frame_cnt;
  logic [11:0] h_pixels, v_lines;

  dvp_capture #(.SKIP_FRAMES(SKIP), .VS_POL(VSP), .H_WIDTH(12), .V_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .dvp_vsync(dvp_vsync),
    .dvp_href(dvp_href), .dvp_data(dvp_data), .vin_vs(vin_vs), .vin_de(vin_de),
    .vin_data(vin_data), .frame_cnt(frame_cnt), .h_pixels(h_pixels),
    .v_lines(v_lines), .frame_done(frame_done), .odd_err(odd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues: expected pixel / frame-close / vin_vs-rise events with arrival cycle.
  typedef struct { logic [15:0] d; int t; } pix_t;
  typedef struct { int fc; int vl; int hp; int t; } fd_t;
  pix_t pq[$];
  fd_t  fq[$];
  int   vsq[$];

  // Reference model: capture mode as seen from frame boundaries.
  typedef enum {M_IDLE, M_WAIT, M_CAPT} m_t;
  m_t mode = M_IDLE;
  int n_vs = 0;
  int exp_fc = 0;
  int cur_lines = 0;
  int last_hp = 0;
  bit exp_odd = 0;

  // Monitor
  initial begin
    pix_t p;
    fd_t  f;
    int   tv;
    logic prev_de = 1'b0, prev_vs = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (vin_de) begin
        if (prev_de) check("de_back_to_back", 1, 0);
        if (pq.size() == 0) check("unexpected_pixel", vin_data, 17'h10000);
        else begin
          p = pq.pop_front();
          check("pix_data", vin_data, p.d);
          check("pix_time", cyc, p.t);
        end
      end
      if (vin_vs && !prev_vs) begin
        if (vsq.size() == 0) check("unexpected_vin_vs", 1, 0);
        else begin
          tv = vsq.pop_front();
          check("vin_vs_time", cyc, tv);
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) check("unexpected_frame_done", 1, 0);
        else begin
          f = fq.pop_front();
          check("fd_frame_cnt", frame_cnt, f.fc);
          check("fd_v_lines", v_lines, f.vl);
          check("fd_h_pixels", h_pixels, f.hp);
          check("fd_time", cyc, f.t);
        end
      end
      prev_de = vin_de;
      prev_vs = vin_vs;
    end
  end

  task automatic set_en(input bit en);
    @(negedge clk);
    cap_en = en;
    if (en && mode == M_IDLE) begin
      mode = M_WAIT; n_vs = 0; exp_odd = 0;
    end else if (!en && mode == M_WAIT) begin
      mode = M_IDLE;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic vs_pulse();
    fd_t f;
    @(negedge clk);
    if (mode == M_CAPT) begin
      exp_fc++;
      f.fc = exp_fc & 16'hFFFF; f.vl = cur_lines; f.hp = last_hp; f.t = cyc + 2;
      fq.push_back(f);
      vsq.push_back(cyc + 2);
      cur_lines = 0;
      if (!cap_en) mode = M_IDLE;
    end else if (mode == M_WAIT) begin
      n_vs++;
      if (n_vs > SKIP) begin
        mode = M_CAPT; cur_lines = 0;
        vsq.push_back(cyc + 2);
      end
    end
    dvp_vsync = (VSP != 0);
    dvp_href  = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) dvp_vsync = (VSP == 0);
    @(negedge clk);
  endtask

  task automatic send_line(input int n, input bit pat);
    logic [7:0] b, hi;
    logic [7:0] pbytes [4];
    pix_t p;
    pbytes = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    hi = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b = pat ? pbytes[i % 4] : 8'($urandom);
      dvp_href = 1'b1;
      dvp_data = b;
      if (mode == M_CAPT) begin
        if (i % 2 == 0) hi = b;
        else begin
          p.d = {hi, b}; p.t = cyc + 2;
          pq.push_back(p);
        end
      end
    end
    @(negedge clk);
    dvp_href = 1'b0;
    dvp_data = 8'($urandom);
    if (mode == M_CAPT) begin
      last_hp = n / 2;
      if (n / 2 > 0) cur_lines++;
      if (n % 2 == 1) exp_odd = 1;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vin_vs"}, vin_vs, 0);
    check({tag, "_vin_de"}, vin_de, 0);
    check({tag, "_vin_data"}, vin_data, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_h_pixels"}, h_pixels, 0);
    check({tag, "_v_lines"}, v_lines, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_odd_err"}, odd_err, 0);
  endtask

  initial begin
    rst_n = 1'b0; cap_en = 1'b0; dvp_href = 1'b0; dvp_data = 8'h00;
    dvp_vsync = (VSP == 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Settle skip: frames 1-2 dropped, frames 3-4 captured (4 lines x 8 bytes).
    set_en(1);
    for (int f = 0; f < 4; f++) begin
      vs_pulse();
      for (int l = 0; l < 4; l++) send_line(8, 0);
    end
    vs_pulse();
    check("frame_cnt_after_4", frame_cnt, 2);
    check("odd_err_clean", odd_err, 0);

    // Directed RGB565 pattern, then an odd-length line.
    send_line(4, 1);
    check("h_pixels_pattern", h_pixels, 2);
    send_line(7, 0);
    check("odd_err_set", odd_err, 1);
    check("h_pixels_odd", h_pixels, 3);
    send_line(10, 0);
    vs_pulse();
    check("odd_err_sticky", odd_err, 1);

    // Stop mid-frame: remaining lines still captured, stop at next vsync.
    send_line(6, 0);
    set_en(0);
    send_line(8, 0);
    send_line(4, 0);
    vs_pulse();
    send_line(8, 0);
    vs_pulse();
    check("frame_cnt_after_stop", frame_cnt, exp_fc);
    check("odd_err_after_stop", odd_err, 1);
    set_en(1);
    check("odd_err_cleared", odd_err, 0);

    // Randomized frames, including single-byte and odd lines.
    for (int f = 0; f < 8; f++) begin
      int nl;
      vs_pulse();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 12), 0);
    end
    vs_pulse();
    check("frame_cnt_random", frame_cnt, exp_fc);
    check("odd_err_random", odd_err, exp_odd);

    // Reset in the middle of a captured line.
    @(negedge clk) begin dvp_href = 1'b1; dvp_data = 8'h12; end
    @(negedge clk) dvp_data = 8'h34;
    @(negedge clk) dvp_data = 8'h56;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    mode = cap_en ? M_WAIT : M_IDLE;
    n_vs = 0; exp_fc = 0; exp_odd = 0; last_hp = 0; cur_lines = 0;
    @(negedge clk) dvp_href = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    send_line(8, 0);
    send_line(8, 0);
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      send_line(8, 0);
      send_line(6, 0);
    end
    vs_pulse();
    check("frame_cnt_after_reset", frame_cnt, 1);

    repeat (10) @(negedge clk);
    check("pix_queue_empty", pq.size(), 0);
    check("fd_queue_empty", fq.size(), 0);
    check("vs_queue_empty", vsq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
